// File: rtl/bits_bytes_pkg.sv
// Shared definitions for the bit-to-byte packer: FSM state encoding,
// byte width and the legal input-width check.
package bits_bytes_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int BYTE_W = 8;

   // Input beat widths that divide a byte evenly.
   function automatic bit in_w_legal(input int w);
      return (w == 1) || (w == 2) || (w == 4) || (w == 8);
   endfunction

endpackage

// File: rtl/bits_to_bytes_packer.sv
// Packs an LSB-first bit stream of IN_W bits per beat into bytes and emits
// them on a valid/ready byte stream, one frame of BYTE_COUNT bytes per start.
// Optional feature macro: BITS_TO_BYTES_FLUSH_EN (in_last ends the frame early,
// zero-padding a partial byte).
module bits_to_bytes_packer
   import bits_bytes_pkg::*;
#(
   parameter int BYTE_COUNT = 256,
   parameter int IN_W       = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_bits,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] out_byte,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(BYTE_COUNT + 1);

   generate
      if (!in_w_legal(IN_W)) begin : g_bad_in_w
         $error("bits_to_bytes_packer: IN_W must be 1, 2, 4 or 8");
      end
   endgenerate

   state_t              r_state;
   state_t              w_state_nxt;
   logic [2:0]          r_bit_cnt;
   logic [CNT_W-1:0]    r_byte_cnt;
   logic [BYTE_W-1:0]   r_acc;
   logic [BYTE_W-1:0]   r_out_byte;
   logic                r_out_valid;
   logic                r_out_last;
   logic                r_done;

   logic [3:0]          w_bit_sum;
   logic                w_byte_end;
   logic                w_last_byte;
   logic                w_flush;
   logic                w_emit;
   logic                w_in_ready;
   logic                w_accept;
   logic                w_out_hs;
   logic [BYTE_W-1:0]   w_acc_ins;

   assign w_bit_sum   = {1'b0, r_bit_cnt} + 4'(IN_W);
   assign w_byte_end  = (w_bit_sum == 4'd8);
   assign w_last_byte = (r_byte_cnt == CNT_W'(BYTE_COUNT - 1));

`ifdef BITS_TO_BYTES_FLUSH_EN
   assign w_flush = in_last;
`else
   logic w_unused_last;
   assign w_unused_last = in_last;
   assign w_flush       = 1'b0;
`endif

   // A beat emits a byte when it fills the byte or (flush build) ends the frame.
   assign w_emit    = w_byte_end || w_flush;
   assign w_accept  = in_valid && w_in_ready;
   assign w_out_hs  = r_out_valid && out_ready;
   // Bits above bit_cnt are always zero, so OR-in places the beat and zero-pads.
   assign w_acc_ins = r_acc | (BYTE_W'(in_bits) << r_bit_cnt);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and input-ready decode; emitting beats stall only on a full, stalled output.
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) w_state_nxt = RUN;
         end
         RUN: begin
            w_in_ready = !w_emit || !r_out_valid || out_ready;
            if (in_valid && w_in_ready && w_emit && (w_last_byte || w_flush))
               w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_out_hs) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Accumulator and bit/byte counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
      end else if (r_state == IDLE && start) begin
         r_acc      <= '0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
      end else if (w_accept) begin
         if (w_emit) begin
            r_acc      <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
         end else begin
            r_acc     <= w_acc_ins;
            r_bit_cnt <= w_bit_sum[2:0];
         end
      end
   end

   // Output register: loads on an emitting beat, clears valid on handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_byte  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_accept && w_emit) begin
         r_out_byte  <= w_acc_ins;
         r_out_valid <= 1'b1;
         r_out_last  <= w_last_byte || w_flush;
      end else if (w_out_hs) begin
         r_out_valid <= 1'b0;
      end
   end

   // Frame-complete pulse following the final byte handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) r_done <= 1'b0;
      else        r_done <= (r_state == DRAIN) && w_out_hs;
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_byte  = r_out_byte;
   assign out_last  = r_out_last;
   assign busy      = (r_state != IDLE);
   assign done      = r_done;

endmodule
